// File: rtl/e203_defines.sv
// e203_defines: shared EXU widths and writeback scheduler constants.
package e203_defines;
    localparam int XLEN            = 32;
    localparam int RFIDX_WIDTH     = 5;
    localparam int ITAG_WIDTH      = 1;
    localparam int WBCK_STARVE_MAX = 4;
    typedef enum logic [1:0] {GNT_NONE, GNT_SHORT, GNT_ALU, GNT_LSU} wbck_gnt_e;
endpackage

// File: rtl/e203_exu_wbck_stage.sv
// e203_exu_wbck_stage: one-entry valid/ready register slice; can drain and reload in the same cycle.
module e203_exu_wbck_stage #(
    parameter int W = 37
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    output logic         room,
    input  logic [W-1:0] push_dat,
    output logic         vld,
    input  logic         rdy,
    output logic [W-1:0] dat
);
    assign room = ~vld | rdy;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld <= 1'b0;
            dat <= '0;
        end else if (push) begin
            vld <= 1'b1;
            dat <= push_dat;
        end else if (rdy) begin
            vld <= 1'b0;
        end
    end
endmodule

// File: rtl/e203_exu_wbck_sched.sv
// e203_exu_wbck_sched: arbitrates short-pipe and OITF-ordered long-pipe results onto the regfile write port.
module e203_exu_wbck_sched #(
    parameter int XLEN       = e203_defines::XLEN,
    parameter int RFIDX_W    = e203_defines::RFIDX_WIDTH,
    parameter int ITAG_W     = e203_defines::ITAG_WIDTH,
    parameter int STARVE_MAX = e203_defines::WBCK_STARVE_MAX
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               short_wbck_i_valid,
    output logic               short_wbck_i_ready,
    input  logic [XLEN-1:0]    short_wbck_i_wdat,
    input  logic [RFIDX_W-1:0] short_wbck_i_rdidx,
    input  logic               alu_longp_i_valid,
    output logic               alu_longp_i_ready,
    input  logic [XLEN-1:0]    alu_longp_i_wdat,
    input  logic [RFIDX_W-1:0] alu_longp_i_rdidx,
    input  logic [ITAG_W-1:0]  alu_longp_i_itag,
    input  logic               lsu_longp_i_valid,
    output logic               lsu_longp_i_ready,
    input  logic [XLEN-1:0]    lsu_longp_i_wdat,
    input  logic [RFIDX_W-1:0] lsu_longp_i_rdidx,
    input  logic [ITAG_W-1:0]  lsu_longp_i_itag,
    input  logic               lsu_longp_i_err,
    input  logic               oitf_empty,
    input  logic [ITAG_W-1:0]  oitf_ret_ptr,
    output logic               oitf_ret_ena,
    output logic               rf_wbck_o_valid,
    input  logic               rf_wbck_o_ready,
    output logic [XLEN-1:0]    rf_wbck_o_wdat,
    output logic [RFIDX_W-1:0] rf_wbck_o_rdidx
);
    import e203_defines::*;

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam int PAY_W = XLEN + RFIDX_W;

    logic             alu_elig, lsu_elig, long_elig, starved;
    logic             stage_rdy, long_acc, load;
    logic [CNT_W-1:0] starve_cnt;
    logic [PAY_W-1:0] load_dat, stage_dat;
    wbck_gnt_e        gnt, long_gnt;

    always_comb begin
        alu_elig  = alu_longp_i_valid & ~oitf_empty & (alu_longp_i_itag == oitf_ret_ptr);
        lsu_elig  = lsu_longp_i_valid & ~oitf_empty & (lsu_longp_i_itag == oitf_ret_ptr);
        long_elig = alu_elig | lsu_elig;
        starved   = long_elig & (starve_cnt == CNT_W'(STARVE_MAX));
        long_gnt  = lsu_elig ? GNT_LSU : GNT_ALU;
        gnt       = starved ? long_gnt : short_wbck_i_valid ? GNT_SHORT : long_elig ? long_gnt : GNT_NONE;
        short_wbck_i_ready = rst_n & (gnt == GNT_SHORT) & stage_rdy;
        alu_longp_i_ready  = rst_n & (gnt == GNT_ALU) & stage_rdy;
        // An errored LSU result only retires the OITF entry, so it never needs the stage.
        lsu_longp_i_ready  = rst_n & (gnt == GNT_LSU) & (stage_rdy | lsu_longp_i_err);
        long_acc     = alu_longp_i_ready | lsu_longp_i_ready;
        oitf_ret_ena = long_acc;
        load     = short_wbck_i_ready | alu_longp_i_ready | (lsu_longp_i_ready & ~lsu_longp_i_err);
        load_dat = short_wbck_i_ready ? {short_wbck_i_wdat, short_wbck_i_rdidx}
                 : alu_longp_i_ready  ? {alu_longp_i_wdat, alu_longp_i_rdidx}
                 :                      {lsu_longp_i_wdat, lsu_longp_i_rdidx};
    end

    always_ff @(posedge clk) begin
        if (!rst_n || long_acc || !long_elig)
            starve_cnt <= '0;
        else if (starve_cnt < CNT_W'(STARVE_MAX))
            starve_cnt <= starve_cnt + CNT_W'(1);
    end

    e203_exu_wbck_stage #(.W(PAY_W)) u_stage (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (load),
        .room     (stage_rdy),
        .push_dat (load_dat),
        .vld      (rf_wbck_o_valid),
        .rdy      (rf_wbck_o_ready),
        .dat      (stage_dat)
    );

    assign {rf_wbck_o_wdat, rf_wbck_o_rdidx} = stage_dat;
endmodule

// File: tb/tb_e203_exu_wbck_sched.sv
// tb_e203_exu_wbck_sched: directed vector table plus randomized run against a queue-based reference model.
module tb_e203_exu_wbck_sched;
    localparam logic [31:0] AD = 32'hAAAA_0001;
    localparam logic [4:0]  AR = 5'd7;
    localparam logic [31:0] LD = 32'hBBBB_0002;
    localparam logic [4:0]  LR = 5'd9;
    localparam int STARVE = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic short_wbck_i_valid, short_wbck_i_ready;
    logic [31:0] short_wbck_i_wdat;
    logic [4:0] short_wbck_i_rdidx;
    logic alu_longp_i_valid, alu_longp_i_ready;
    logic [31:0] alu_longp_i_wdat;
    logic [4:0] alu_longp_i_rdidx;
    logic alu_longp_i_itag;
    logic lsu_longp_i_valid, lsu_longp_i_ready;
    logic [31:0] lsu_longp_i_wdat;
    logic [4:0] lsu_longp_i_rdidx;
    logic lsu_longp_i_itag, lsu_longp_i_err;
    logic oitf_empty, oitf_ret_ptr, oitf_ret_ena;
    logic rf_wbck_o_valid, rf_wbck_o_ready;
    logic [31:0] rf_wbck_o_wdat;
    logic [4:0] rf_wbck_o_rdidx;

    int passed = 0;
    int total = 0;

    always #5 clk = ~clk;

    e203_exu_wbck_sched dut (
        .clk(clk), .rst_n(rst_n),
        .short_wbck_i_valid(short_wbck_i_valid), .short_wbck_i_ready(short_wbck_i_ready),
        .short_wbck_i_wdat(short_wbck_i_wdat), .short_wbck_i_rdidx(short_wbck_i_rdidx),
        .alu_longp_i_valid(alu_longp_i_valid), .alu_longp_i_ready(alu_longp_i_ready),
        .alu_longp_i_wdat(alu_longp_i_wdat), .alu_longp_i_rdidx(alu_longp_i_rdidx),
        .alu_longp_i_itag(alu_longp_i_itag),
        .lsu_longp_i_valid(lsu_longp_i_valid), .lsu_longp_i_ready(lsu_longp_i_ready),
        .lsu_longp_i_wdat(lsu_longp_i_wdat), .lsu_longp_i_rdidx(lsu_longp_i_rdidx),
        .lsu_longp_i_itag(lsu_longp_i_itag), .lsu_longp_i_err(lsu_longp_i_err),
        .oitf_empty(oitf_empty), .oitf_ret_ptr(oitf_ret_ptr), .oitf_ret_ena(oitf_ret_ena),
        .rf_wbck_o_valid(rf_wbck_o_valid), .rf_wbck_o_ready(rf_wbck_o_ready),
        .rf_wbck_o_wdat(rf_wbck_o_wdat), .rf_wbck_o_rdidx(rf_wbck_o_rdidx)
    );

    typedef struct {
        logic rst; logic sv; logic [31:0] sd; logic [4:0] sr;
        logic av; logic ai; logic lv; logic li; logic le;
        logic oe; logic ptr; logic rfr;
        logic xs; logic xa; logic xl; logic xret; logic xvld; logic xpay;
        logic [31:0] xwd; logic [4:0] xrd;
    } vec_t;

    typedef struct { logic [31:0] d; logic [4:0] r; } ent_t;

    vec_t vq[$];
    ent_t pend[$];
    int losses;

    task automatic chk(input string nm, input int cyc, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s @%0d: got %h expected %h", nm, cyc, got, exp);
        else passed++;
    endtask

    task automatic idle_inputs();
        short_wbck_i_valid = 0; short_wbck_i_wdat = 0; short_wbck_i_rdidx = 0;
        alu_longp_i_valid = 0; alu_longp_i_wdat = AD; alu_longp_i_rdidx = AR; alu_longp_i_itag = 0;
        lsu_longp_i_valid = 0; lsu_longp_i_wdat = LD; lsu_longp_i_rdidx = LR; lsu_longp_i_itag = 0;
        lsu_longp_i_err = 0; oitf_empty = 1; oitf_ret_ptr = 0; rf_wbck_o_ready = 1;
    endtask

    // Reference: decide the winner from the arbitration rules, hold the output stage as a queue.
    task automatic model_cycle(input int cyc);
        bit ae, lse, lng, room;
        int win;
        bit es, ea, el;
        ae   = alu_longp_i_valid && !oitf_empty && alu_longp_i_itag == oitf_ret_ptr;
        lse  = lsu_longp_i_valid && !oitf_empty && lsu_longp_i_itag == oitf_ret_ptr;
        assert (!(ae && lse)) else $error("illegal stimulus: both long pipes eligible");
        lng  = ae || lse;
        room = pend.size() == 0 || rf_wbck_o_ready;
        if (lng && losses >= STARVE) win = lse ? 3 : 2;
        else if (short_wbck_i_valid) win = 1;
        else if (lng) win = lse ? 3 : 2;
        else win = 0;
        es = rst_n && win == 1 && room;
        ea = rst_n && win == 2 && room;
        el = rst_n && win == 3 && (room || lsu_longp_i_err);
        chk("rnd_short_ready", cyc, short_wbck_i_ready, es);
        chk("rnd_alu_ready", cyc, alu_longp_i_ready, ea);
        chk("rnd_lsu_ready", cyc, lsu_longp_i_ready, el);
        chk("rnd_ret_ena", cyc, oitf_ret_ena, ea || el);
        chk("rnd_out_valid", cyc, rf_wbck_o_valid, pend.size() != 0);
        if (pend.size() != 0) begin
            chk("rnd_out_wdat", cyc, rf_wbck_o_wdat, pend[0].d);
            chk("rnd_out_rdidx", cyc, rf_wbck_o_rdidx, pend[0].r);
        end
        if (!rst_n) begin
            pend.delete();
            losses = 0;
        end else begin
            if (pend.size() != 0 && rf_wbck_o_ready) void'(pend.pop_front());
            if (es) pend.push_back('{short_wbck_i_wdat, short_wbck_i_rdidx});
            if (ea) pend.push_back('{alu_longp_i_wdat, alu_longp_i_rdidx});
            if (el && !lsu_longp_i_err) pend.push_back('{lsu_longp_i_wdat, lsu_longp_i_rdidx});
            losses = (lng && !(ea || el)) ? ((losses + 1 > STARVE) ? STARVE : losses + 1) : 0;
        end
    endtask

    initial begin
        //            rst sv sd        sr av ai lv li le oe pt rf  xs xa xl xr xv xp xwd       xrd
        vq.push_back('{0, 1, 32'hdead, 3, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1, 32'h0,    0});
        vq.push_back('{1, 1, 32'h1234, 5, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 1, 32'h0,    0});
        vq.push_back('{1, 0, 32'h0,    0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 1, 32'h1234, 5});
        vq.push_back('{1, 0, 32'h0,    0, 1, 0, 1, 1, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 32'h0,    0});
        vq.push_back('{1, 0, 32'h0,    0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 1, 1, LD,       LR});
        vq.push_back('{1, 0, 32'h0,    0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 1, AD,       AR});
        vq.push_back('{1, 1, 32'h100,  1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 32'h0,    0});
        vq.push_back('{1, 1, 32'h101,  2, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 1, 32'h100,  1});
        vq.push_back('{1, 1, 32'h102,  3, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 1, 32'h101,  2});
        vq.push_back('{1, 1, 32'h103,  4, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 1, 32'h102,  3});
        vq.push_back('{1, 1, 32'h104,  5, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 1, 1, 32'h103,  4});
        vq.push_back('{1, 1, 32'h104,  5, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 1, AD,       AR});
        vq.push_back('{1, 1, 32'h200,  6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h104,  5});
        vq.push_back('{1, 1, 32'h200,  6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h104,  5});
        vq.push_back('{1, 1, 32'h200,  6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h104,  5});
        vq.push_back('{1, 1, 32'h200,  6, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 1, 32'h104,  5});
        vq.push_back('{1, 1, 32'h201,  7, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 1, 32'h200,  6});
        vq.push_back('{1, 0, 32'h0,    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h201,  7});
        vq.push_back('{1, 0, 32'h0,    0, 0, 0, 1, 1, 1, 0, 1, 0, 0, 0, 1, 1, 1, 1, 32'h201,  7});
        vq.push_back('{1, 0, 32'h0,    0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 32'h201,  7});
        vq.push_back('{0, 1, 32'h300,  8, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h201,  7});
        vq.push_back('{0, 1, 32'h300,  8, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0,    0});
        vq.push_back('{1, 0, 32'h0,    0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1, 32'h0,    0});

        idle_inputs();
        rst_n = 0;
        repeat (2) @(posedge clk);
        foreach (vq[i]) begin
            @(posedge clk);
            #1;
            rst_n = vq[i].rst;
            short_wbck_i_valid = vq[i].sv; short_wbck_i_wdat = vq[i].sd; short_wbck_i_rdidx = vq[i].sr;
            alu_longp_i_valid = vq[i].av; alu_longp_i_itag = vq[i].ai;
            lsu_longp_i_valid = vq[i].lv; lsu_longp_i_itag = vq[i].li; lsu_longp_i_err = vq[i].le;
            oitf_empty = vq[i].oe; oitf_ret_ptr = vq[i].ptr; rf_wbck_o_ready = vq[i].rfr;
            #3;
            chk("vec_short_ready", i, short_wbck_i_ready, vq[i].xs);
            chk("vec_alu_ready", i, alu_longp_i_ready, vq[i].xa);
            chk("vec_lsu_ready", i, lsu_longp_i_ready, vq[i].xl);
            chk("vec_ret_ena", i, oitf_ret_ena, vq[i].xret);
            chk("vec_out_valid", i, rf_wbck_o_valid, vq[i].xvld);
            if (vq[i].xpay) begin
                chk("vec_out_wdat", i, rf_wbck_o_wdat, vq[i].xwd);
                chk("vec_out_rdidx", i, rf_wbck_o_rdidx, vq[i].xrd);
            end
        end

        losses = 0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            rst_n = (c == 0) ? 1'b0 : ($urandom_range(0, 63) != 0);
            short_wbck_i_valid = $urandom_range(0, 1);
            short_wbck_i_wdat = $urandom;
            short_wbck_i_rdidx = 5'($urandom);
            alu_longp_i_valid = $urandom_range(0, 9) < 6;
            alu_longp_i_wdat = $urandom;
            alu_longp_i_rdidx = 5'($urandom);
            alu_longp_i_itag = 1'($urandom);
            lsu_longp_i_valid = $urandom_range(0, 9) < 6;
            lsu_longp_i_wdat = $urandom;
            lsu_longp_i_rdidx = 5'($urandom);
            lsu_longp_i_itag = 1'($urandom);
            lsu_longp_i_err = $urandom_range(0, 3) == 0;
            oitf_empty = $urandom_range(0, 3) == 0;
            oitf_ret_ptr = 1'($urandom);
            rf_wbck_o_ready = $urandom_range(0, 9) < 7;
            if (alu_longp_i_valid && lsu_longp_i_valid && alu_longp_i_itag == oitf_ret_ptr
                && lsu_longp_i_itag == oitf_ret_ptr)
                lsu_longp_i_itag = ~oitf_ret_ptr;
            #3;
            model_cycle(c);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/e203_exu_wbck_sched.md
Name: e203_exu_wbck_sched

Overview:
- Scheduler for the single regfile write port in the EXU.
- Arbitrates three writeback sources:
  - short-pipe ALU results (no itag)
  - OITF-tracked ALU long-pipe results
  - OITF-tracked LSU long-pipe results
- Long-pipe sources are eligible only when their itag matches the OITF head. A saturating starvation counter stops short-pipe traffic from blocking OITF retirement forever.
- The winner is registered into a one-entry output stage that drives the regfile write port.

Parameters:
- XLEN, 32, data width
- RFIDX_W, 5, register index width
- ITAG_W, 1, OITF itag width (OITF depth 2)
- STARVE_MAX, 4, cycles a matched long-pipe request may lose before it is forced to win

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- short_wbck_i_valid  in  1  short-pipe request
- short_wbck_i_ready  out  1  short-pipe accept
- short_wbck_i_wdat  in  XLEN  short-pipe data
- short_wbck_i_rdidx  in  RFIDX_W  short-pipe destination
- alu_longp_i_valid  in  1  ALU long-pipe request
- alu_longp_i_ready  out  1  ALU long-pipe accept
- alu_longp_i_wdat  in  XLEN  data
- alu_longp_i_rdidx  in  RFIDX_W  destination
- alu_longp_i_itag  in  ITAG_W  OITF tag
- lsu_longp_i_valid  in  1  LSU long-pipe request
- lsu_longp_i_ready  out  1  LSU accept
- lsu_longp_i_wdat  in  XLEN  data
- lsu_longp_i_rdidx  in  RFIDX_W  destination
- lsu_longp_i_itag  in  ITAG_W  OITF tag
- lsu_longp_i_err  in  1  bus error; retire without regfile write
- oitf_empty  in  1  OITF holds no entry
- oitf_ret_ptr  in  ITAG_W  itag at OITF head
- oitf_ret_ena  out  1  pop OITF head this cycle
- rf_wbck_o_valid  out  1  regfile write request
- rf_wbck_o_ready  in  1  regfile accepts
- rf_wbck_o_wdat  out  XLEN  write data
- rf_wbck_o_rdidx  out  RFIDX_W  write index

Clocking and reset:
- One clock, clk.
- rst_n is synchronous, active-low.

Behaviour:
- Eligibility:
  - alu_elig = alu_longp_i_valid & ~oitf_empty & (alu_longp_i_itag == oitf_ret_ptr)
  - lsu_elig is the same, using the LSU inputs.
  - long_elig = alu_elig | lsu_elig.
  - alu_elig & lsu_elig together is illegal (bench assertion); if it occurs, LSU wins.
- Stage availability: stage_rdy = ~out_vld | rf_wbck_o_ready.
- Grant:
  - If long_elig & (starve_cnt == STARVE_MAX): long winner (LSU over ALU).
  - Else if short_wbck_i_valid: short.
  - Else if long_elig: long winner.
  - Else: none.
- Ready outputs:
  - Asserted only for the granted source, and only when stage_rdy.
  - Exception: a granted LSU request with err=1 is ready regardless of stage_rdy.
  - Ready depends combinationally on valid/itag; there is no ready-before-valid guarantee.
- Accept = granted valid & its ready.
  - Short or long accept without err loads the output stage (wdat, rdidx) and sets out_vld.
  - LSU accept with err does not load the stage.
- Output stage:
  - out_vld clears on rf_wbck_o_ready when there is no new load.
  - Simultaneous drain and load keeps out_vld=1 with the new data.
  - Latency is exactly 1 cycle from accept to rf_wbck_o_valid.
  - Sustained throughput is 1 per cycle while rf_wbck_o_ready=1.
  - Payload holds stable while valid & ~ready.
- oitf_ret_ena = long-pipe accept, combinational in the accept cycle. This includes err retires. Short accepts never assert it.
- starve_cnt, width clog2(STARVE_MAX+1):
  - Reset to 0 when long accepted or ~long_elig.
  - Increment when long_elig & ~long accepted & starve_cnt < STARVE_MAX.
  - Otherwise hold (saturate).
  - A long request stalled by ~stage_rdy still counts.
- Mid-operation reset: all state clears the next edge; an in-flight stage entry is discarded.
- Reset values:
  - out_vld=0, rf_wbck_o_wdat=0, rf_wbck_o_rdidx=0, starve_cnt=0.
  - oitf_ret_ena=0 and all readies=0 while rst_n=0.
- Writes to rdidx 0 pass through; the regfile discards them.

Decomposition:
- Shared package e203_defines: XLEN, RFIDX_WIDTH, ITAG_WIDTH, WBCK_STARVE_MAX.
- Sub-module: e203_exu_wbck_stage (one-entry valid/ready pipeline register, payload XLEN+RFIDX_W), reusable elsewhere.

Test Plan:
1. Reset, then short valid with wdat=0x1234, rdidx=5, rf ready=1 -> short ready=1; next cycle rf_wbck_o_valid=1, wdat=0x1234, rdidx=5; oitf_ret_ena=0 throughout.
2. oitf_ret_ptr=1, alu itag=0 valid, lsu itag=1 valid, no short -> LSU accepted, oitf_ret_ena=1 that cycle, ALU ready=0. Then ret_ptr=0 -> ALU accepted next.
3. Short valid every cycle while ALU itag matches head -> ALU blocked 4 cycles (starve_cnt 0..4). Cycle 5: ALU granted, short ready=0, starve_cnt returns to 0.
4. rf_wbck_o_ready=0 for 3 cycles with stage full -> all input readies 0, output payload stable. Ready=1 with new short pending -> drain and load same cycle, back-to-back valid.
5. LSU itag matches head, err=1, stage full, rf ready=0 -> lsu ready=1, oitf_ret_ena=1, output stage unchanged, no new rf write.
6. rst_n=0 asserted while out_vld=1 -> next edge out_vld=0, wdat=0, rdidx=0, starve_cnt=0; oitf_ret_ena=0 during reset.
